// File: rtl/run_code_pkg.sv
// Shared definitions for the run-code line (transmitter and receiver).
// Holds the FSM state encoding, default run lengths and the bit -> run
// length mapping so both ends of the line agree on the symbol format.
package run_code_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TERM = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int unsigned SHORT_RUN_DEF = 2;
  localparam int unsigned LONG_RUN_DEF  = 4;

  // Number of ones that encode one data bit.
  function automatic int unsigned run_len(input logic b,
                                          input int unsigned short_run = SHORT_RUN_DEF,
                                          input int unsigned long_run  = LONG_RUN_DEF);
    return b ? long_run : short_run;
  endfunction

endpackage

// File: rtl/run_code_counter.sv
// Loadable down-counter used for run lengths and the inter-byte gap.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val (has priority over en)
//   en         : count down by one, saturating at zero
//   load_val   : value loaded on load
//   zero       : count is zero (last cycle of the timed interval)
module run_code_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (en && !zero)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/run_code_tx.sv
// Serial run-length symbol transmitter.
// Takes a byte over DATA_VALID/DATA_READY and sends it MSB-first on BIT.
// Each data bit becomes a run of ones (SHORT_RUN for 0, LONG_RUN for 1)
// followed by exactly one zero; the line idles at zero.
// Optional feature macro RUNTX_GAP_EN: adds GAP_LEN idle zeros after each byte.
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset
//   DATA        : byte to send, taken when DATA_VALID && DATA_READY
//   DATA_VALID  : producer has a byte
//   DATA_READY  : a byte can be taken this cycle
//   BIT         : registered serial line
//   BUSY        : byte or gap in progress
//   BYTE_DONE   : pulse on the final terminator zero of a byte
module run_code_tx
  import run_code_pkg::*;
#(
  parameter int unsigned SHORT_RUN = SHORT_RUN_DEF,
  parameter int unsigned LONG_RUN  = LONG_RUN_DEF,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned GAP_LEN   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       BIT,
  output logic       BUSY,
  output logic       BYTE_DONE
);

  // The counter holds length-1, so every length must fit in CNT_W bits.
  // GAP_LEN is checked in both builds so the macro can be flipped freely.
  if (SHORT_RUN < 1 || LONG_RUN <= SHORT_RUN || LONG_RUN >= (1 << CNT_W)) begin : g_bad_run
    $error("run_code_tx: need 1 <= SHORT_RUN < LONG_RUN < 2**CNT_W");
  end
  if (GAP_LEN < 1 || GAP_LEN >= (1 << CNT_W)) begin : g_bad_gap
    $error("run_code_tx: need 1 <= GAP_LEN < 2**CNT_W");
  end

  state_e           state, state_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       idx;
  logic             final_sym;
  logic             accept;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  assign final_sym = (idx == 3'd0);
  assign accept    = DATA_VALID && DATA_READY;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (cnt_zero) state_n = TERM;
      TERM: begin
        if (!final_sym)   state_n = RUN;
`ifdef RUNTX_GAP_EN
        else              state_n = GAP;
`else
        else if (accept)  state_n = RUN;
        else              state_n = IDLE;
`endif
      end
      GAP:  if (cnt_zero) state_n = accept ? RUN : IDLE;
      default:            state_n = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    DATA_READY = 1'b0;
    BUSY       = 1'b1;
    BYTE_DONE  = 1'b0;
    case (state)
      IDLE: begin
        DATA_READY = 1'b1;
        BUSY       = 1'b0;
      end
      TERM: begin
        BYTE_DONE  = final_sym;
`ifndef RUNTX_GAP_EN
        // Final terminator doubles as the accept slot for the next byte.
        DATA_READY = final_sym;
`endif
      end
      GAP:     DATA_READY = cnt_zero;
      default: ;
    endcase
  end

  // Shift register / counter control. The counter is loaded with the
  // length of the symbol that starts next cycle, taken from the MSB of
  // the shift register value that will hold then.
  always_comb begin
    shreg_n  = shreg;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (accept)
      shreg_n = DATA;
    else if (state == TERM && !final_sym)
      shreg_n = {shreg[6:0], 1'b0};

    if (accept || (state == TERM && !final_sym)) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(run_len(shreg_n[7], SHORT_RUN, LONG_RUN) - 1);
    end
`ifdef RUNTX_GAP_EN
    else if (state == TERM) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(GAP_LEN - 1);
    end
`endif
    cnt_en = (state == RUN) || (state == GAP);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg <= '0;
      idx   <= '0;
      BIT   <= 1'b0;
    end else begin
      shreg <= shreg_n;
      if (accept)                          idx <= 3'd7;
      else if (state == TERM && !final_sym) idx <= idx - 3'd1;
      // Registered line: high exactly in the cycles spent in RUN.
      BIT <= (state_n == RUN);
    end
  end

  run_code_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_run_code_tx.sv
// Bench for run_code_tx: line-schedule reference model plus a behavioural
// run-code receiver fed from BIT.
module tb_run_code_tx;

  localparam int SHORT = 2;
  localparam int LONG  = 4;
`ifdef RUNTX_GAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       DATA_READY, BIT, BUSY, BYTE_DONE;

  run_code_tx dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA       (DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .BIT        (BIT),
    .BUSY       (BUSY),
    .BYTE_DONE  (BYTE_DONE)
  );

  always #5 CLK = ~CLK;

  // Expected future line cycles: one entry per clock, head = current cycle.
  typedef struct packed { logic b; logic done; } sym_t;
  sym_t q[$];
  logic [7:0] sent[$];
  int acc_cnt = 0;

  // Receiver model
  int   ones = 0, rx_pulses = 0, bad_runs = 0;
  logic rx_bits[$];

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wave(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      int n;
      n = d[i] ? LONG : SHORT;
      for (int k = 0; k < n; k++) q.push_back('{b: 1'b1, done: 1'b0});
      q.push_back('{b: 1'b0, done: (i == 0)});
    end
    for (int k = 0; k < GAP; k++) q.push_back('{b: 1'b0, done: 1'b0});
  endtask

  task automatic rx_clear();
    ones = 0; rx_pulses = 0; bad_runs = 0;
    rx_bits.delete();
    sent.delete();
  endtask

  // One clock: advance the model across the edge, then compare all outputs.
  task automatic tick();
    logic       r, acc;
    logic [7:0] d;
    logic [3:0] exp;
    sym_t       h;
    r   = RESET;
    acc = !r && DATA_VALID && (q.size() <= 1);
    d   = DATA;
    @(posedge CLK);
    #1;
    if (r) q.delete();
    else begin
      if (q.size() != 0) void'(q.pop_front());
      if (acc) begin
        push_wave(d);
        sent.push_back(d);
        acc_cnt++;
      end
    end
    h = '{b: 1'b0, done: 1'b0};
    if (q.size() != 0) h = q[0];
    exp = {h.b, q.size() != 0, h.done, q.size() <= 1};
    chk("cycle{bit,busy,done,ready}", int'({BIT, BUSY, BYTE_DONE, DATA_READY}), int'(exp));
    if (BIT) ones++;
    else begin
      if (ones == SHORT)     begin rx_bits.push_back(1'b0); rx_pulses++; end
      else if (ones == LONG) begin rx_bits.push_back(1'b1); rx_pulses++; end
      else if (ones != 0)    bad_runs++;
      ones = 0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin tick(); w++; end
    chk("drain_timeout", int'(q.size() != 0), 0);
    tick();
  endtask

  typedef struct { logic [7:0] data; int len; } vec_t;
  vec_t vecs[6];

  initial begin
    int n, z, a0, w, done_cnt;
    logic [7:0] rb;

    vecs[0] = '{8'h00, 24};
    vecs[1] = '{8'hA5, 32};
    vecs[2] = '{8'hFF, 40};
    vecs[3] = '{8'h80, 26};
    vecs[4] = '{8'h01, 26};
    vecs[5] = '{8'h3C, 32};

    // Reset state
    tick(); tick();
    chk("reset_outputs", int'({BIT, BUSY, BYTE_DONE, DATA_READY}), 4'b0001);
    RESET = 1'b0;
    tick();

    // Table: byte duration from first symbol cycle to BYTE_DONE
    for (int v = 0; v < 6; v++) begin
      rx_clear();
      DATA = vecs[v].data; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      n = 1;
      while (!BYTE_DONE && n < 100) begin tick(); n++; end
      chk($sformatf("len_%02h", vecs[v].data), n, vecs[v].len);
      drain();
      chk($sformatf("busy_after_%02h", vecs[v].data), int'(BUSY), 0);
      rb = '0;
      for (int i = 0; i < 8 && i < rx_bits.size(); i++) rb[7-i] = rx_bits[i];
      chk($sformatf("decode_%02h", vecs[v].data), int'(rb), int'(vecs[v].data));
    end

    // Back-to-back: VALID held, 0xFF then 0x00
    a0 = acc_cnt;
    DATA = 8'hFF; DATA_VALID = 1'b1;
    tick();
    DATA = 8'h00;
    w = 0;
    while (!BYTE_DONE && w < 100) begin tick(); w++; end
    z = 1; w = 0;
    while (w < 20) begin
      tick(); w++;
      if (acc_cnt == a0 + 2) DATA_VALID = 1'b0;
      if (BIT) break;
      z++;
    end
    chk("b2b_zeros", z, 1 + GAP);
    chk("b2b_accepts", acc_cnt - a0, 2);
    DATA_VALID = 1'b0;
    drain();

    // Reset during the third symbol of 0xFF
    DATA = 8'hFF; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    chk("pre_reset_bit", int'(BIT), 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_mid_bit", int'(BIT), 0);
    chk("rst_mid_done", int'(BYTE_DONE), 0);
    chk("rst_mid_ready", int'(DATA_READY), 1);
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (BYTE_DONE) done_cnt++; end
    chk("rst_no_done", done_cnt, 0);

    // VALID/DATA wiggled while not ready
    rx_clear();
    DATA = 8'h5A; DATA_VALID = 1'b1;
    tick();
    w = 0;
    while (q.size() > 1 && w < 100) begin
      DATA = 8'($urandom);
      DATA_VALID = 1'($urandom);
      tick(); w++;
    end
    DATA_VALID = 1'b0;
    drain();
    rb = '0;
    for (int i = 0; i < 8 && i < rx_bits.size(); i++) rb[7-i] = rx_bits[i];
    chk("mid_byte_data", int'(rb), 8'h5A);
    chk("mid_byte_pulses", rx_pulses, 8);

    // Random loopback
    rx_clear();
    for (int b = 0; b < 200; b++) begin
      int idle;
      idle = $urandom_range(0, 3);
      if (idle > 0) begin
        DATA_VALID = 1'b0;
        repeat (idle) tick();
      end
      DATA = 8'($urandom);
      DATA_VALID = 1'b1;
      a0 = acc_cnt; w = 0;
      while (acc_cnt == a0 && w < 100) begin tick(); w++; end
      if (acc_cnt == a0) chk("rand_accept_timeout", 1, 0);
    end
    DATA_VALID = 1'b0;
    drain();
    chk("rand_pulses", rx_pulses, 8 * sent.size());
    chk("rand_bytes", sent.size(), 200);
    chk("rand_bad_runs", bad_runs, 0);
    for (int b = 0; b < sent.size(); b++) begin
      rb = '0;
      for (int i = 0; i < 8; i++)
        if (8*b + i < rx_bits.size()) rb[7-i] = rx_bits[8*b + i];
      chk("rand_decode", int'(rb), int'(sent[b]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
